// File: rtl/multi_channel_sequencer.sv
// multi_channel_sequencer: NUM_CH square-wave tone channels gated by per-channel STEPS-bit patterns.
// Latency: a step advance changes gating the cycle after step_tick; audio_out is registered one cycle behind the gate.
// Backpressure: none; pattern writes are always accepted, and writes to a channel index >= NUM_CH are dropped.
//
// Ports: CLOCK_50/reset (async active-high); run enables tempo and audio; tempo_period is cycles per step
// (values below 2 act as 2); tone_half_period packs NUM_CH half-periods of DIV_W bits (0 mutes the channel);
// edit_ch/pattern_we/pattern_wdata edit one pattern; pattern_view shows pattern[edit_ch];
// audio_out, step_idx and step_tick are the play outputs.
// Optional: define LOOP_LEN_EN to add input loop_len, which shortens the loop to clamp(loop_len, 1, STEPS) steps.
module multi_channel_sequencer #(
    parameter int NUM_CH  = 4,
    parameter int STEPS   = 16,
    parameter int CH_W    = 2,
    parameter int STEP_W  = 4,
    parameter int DIV_W   = 20,
    parameter int TEMPO_W = 28
) (
    input  logic                      CLOCK_50,
    input  logic                      reset,
    input  logic                      run,
    input  logic [TEMPO_W-1:0]        tempo_period,
    input  logic [NUM_CH*DIV_W-1:0]   tone_half_period,
    input  logic [CH_W-1:0]           edit_ch,
    input  logic                      pattern_we,
    input  logic [STEPS-1:0]          pattern_wdata,
`ifdef LOOP_LEN_EN
    input  logic [STEP_W:0]           loop_len,
`endif
    output logic [NUM_CH-1:0]         audio_out,
    output logic [STEPS-1:0]          pattern_view,
    output logic [STEP_W-1:0]         step_idx,
    output logic                      step_tick
);

    localparam int LW = STEP_W + 1;

    logic [TEMPO_W-1:0] tempo_cnt;
    logic [TEMPO_W-1:0] period_eff;
    logic [LW-1:0]      loop_eff;
    logic [LW-1:0]      step_inc;
    logic [STEP_W-1:0]  step_next;
    logic [STEPS-1:0]   pattern [NUM_CH];

    // Periods of 0 and 1 would make a tick every cycle or never; floor at 2.
    assign period_eff = (tempo_period < TEMPO_W'(2)) ? TEMPO_W'(2) : tempo_period;

    // ">=" rather than "==" so that shrinking the period below the current count wraps at once.
    assign step_tick = run && (tempo_cnt >= period_eff - TEMPO_W'(1));

`ifdef LOOP_LEN_EN
    always_comb begin
        loop_eff = loop_len;
        if (loop_len == '0) begin
            loop_eff = LW'(1);
        end else if (loop_len > LW'(STEPS)) begin
            loop_eff = LW'(STEPS);
        end
    end
`else
    assign loop_eff = LW'(STEPS);
`endif

    // Comparing with ">=" also sends the pointer to 0 when the loop is shortened below it.
    assign step_inc  = {1'b0, step_idx} + LW'(1);
    assign step_next = (step_inc >= loop_eff) ? '0 : step_inc[STEP_W-1:0];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tempo_cnt <= '0;
            step_idx  <= '0;
        end else if (!run) begin
            tempo_cnt <= '0;
        end else if (step_tick) begin
            tempo_cnt <= '0;
            step_idx  <= step_next;
        end else begin
            tempo_cnt <= tempo_cnt + TEMPO_W'(1);
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                pattern[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (pattern_we && (edit_ch == CH_W'(c))) begin
                    pattern[c] <= pattern_wdata;
                end
            end
        end
    end

    // Out-of-range edit_ch matches no channel and so reads as 0.
    always_comb begin
        pattern_view = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (edit_ch == CH_W'(c)) begin
                pattern_view = pattern[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [DIV_W-1:0] half;
        logic [DIV_W-1:0] tone_cnt;
        logic             gate;
        logic             audio_q;

        assign half = tone_half_period[c*DIV_W +: DIV_W];
        assign gate = run && pattern[c][step_idx] && (half != '0);

        // Closed gate parks the output low, so every new note starts low.
        always_ff @(posedge CLOCK_50 or posedge reset) begin
            if (reset) begin
                tone_cnt <= '0;
                audio_q  <= 1'b0;
            end else if (!gate) begin
                tone_cnt <= '0;
                audio_q  <= 1'b0;
            end else if (tone_cnt >= half - DIV_W'(1)) begin
                tone_cnt <= '0;
                audio_q  <= ~audio_q;
            end else begin
                tone_cnt <= tone_cnt + DIV_W'(1);
            end
        end

        assign audio_out[c] = audio_q;
    end

endmodule

// File: tb/tb_multi_channel_sequencer.sv
module tb_multi_channel_sequencer;

    localparam int NCH = 3;
    localparam int ST  = 16;
    localparam int CW  = 2;
    localparam int SW  = 4;
    localparam int DW  = 20;
    localparam int TW  = 28;

    logic              clk = 1'b0;
    logic              rst;
    logic              run;
    logic [TW-1:0]     tempo;
    logic [NCH*DW-1:0] halfv;
    logic [CW-1:0]     edit_ch;
    logic              we;
    logic [ST-1:0]     wdata;
`ifdef LOOP_LEN_EN
    logic [SW:0]       loop_len;
`endif
    logic [NCH-1:0]    audio_out;
    logic [ST-1:0]     view;
    logic [SW-1:0]     step_idx;
    logic              step_tick;

    always #5 clk = ~clk;

    multi_channel_sequencer #(
        .NUM_CH(NCH), .STEPS(ST), .CH_W(CW), .STEP_W(SW), .DIV_W(DW), .TEMPO_W(TW)
    ) dut (
        .CLOCK_50(clk),
        .reset(rst),
        .run(run),
        .tempo_period(tempo),
        .tone_half_period(halfv),
        .edit_ch(edit_ch),
        .pattern_we(we),
        .pattern_wdata(wdata),
`ifdef LOOP_LEN_EN
        .loop_len(loop_len),
`endif
        .audio_out(audio_out),
        .pattern_view(view),
        .step_idx(step_idx),
        .step_tick(step_tick)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: step position as a phase count, each tone as "gated cycles so far".
    int            m_phase;
    int            m_step;
    int            m_g [NCH];
    logic [ST-1:0] m_pat [NCH];

    int             obs_ticks;
    logic           last_tick;
    logic [NCH-1:0] seen_audio;

    typedef struct {
        logic [CW-1:0] ch;
        logic          we;
        logic [ST-1:0] wd;
        logic [ST-1:0] exp_view;
    } vec_t;
    vec_t tbl [6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic int eff_p();
        return (tempo < TW'(2)) ? 2 : int'(tempo);
    endfunction

    function automatic int half_of(input int c);
        return int'(halfv[c*DW +: DW]);
    endfunction

    function automatic int loop_l();
`ifdef LOOP_LEN_EN
        if (loop_len == '0) return 1;
        if (int'(loop_len) > ST) return ST;
        return int'(loop_len);
`else
        return ST;
`endif
    endfunction

    task automatic set_half(input int c, input int v);
        halfv[c*DW +: DW] = DW'(v);
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_step  = 0;
        for (int c = 0; c < NCH; c++) begin
            m_g[c]   = 0;
            m_pat[c] = '0;
        end
    endtask

    task automatic check_all();
        logic [NCH-1:0] ea;
        logic [ST-1:0]  ev;
        int             h;
        int             ec;
        for (int c = 0; c < NCH; c++) begin
            h = half_of(c);
            ea[c] = (h != 0) && (((m_g[c] / h) % 2) == 1);
        end
        ec = int'(edit_ch);
        ev = (ec < NCH) ? m_pat[ec] : '0;
        chk("audio_out", 64'(audio_out), 64'(ea));
        chk("step_idx", 64'(step_idx), 64'(m_step));
        chk("step_tick", 64'(step_tick), 64'(run && (m_phase >= eff_p() - 1)));
        chk("pattern_view", 64'(view), 64'(ev));
    endtask

    // Everything the coming clock edge does, evaluated from the pre-edge state.
    task automatic model_edge();
        bit tick;
        bit gate;
        int ec;
        tick = run && (m_phase >= eff_p() - 1);
        for (int c = 0; c < NCH; c++) begin
            gate   = run && m_pat[c][m_step] && (half_of(c) != 0);
            m_g[c] = gate ? m_g[c] + 1 : 0;
        end
        ec = int'(edit_ch);
        if (we && ec < NCH) m_pat[ec] = wdata;
        if (!run) begin
            m_phase = 0;
        end else if (tick) begin
            m_phase = 0;
            m_step  = (m_step + 1 >= loop_l()) ? 0 : m_step + 1;
        end else begin
            m_phase++;
        end
    endtask

    // Called just after a falling edge with this cycle's inputs applied.
    task automatic cyc();
        #1;
        last_tick = step_tick;
        if (step_tick) obs_ticks++;
        seen_audio |= audio_out;
        check_all();
        model_edge();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int   s0;
        logic hi_s0;
        logic hi_off;

        rst = 1'b1; run = 1'b0; tempo = '0; halfv = '0;
        edit_ch = '0; we = 1'b0; wdata = '0;
`ifdef LOOP_LEN_EN
        loop_len = 5'd16;
`endif
        model_reset();
        obs_ticks = 0; seen_audio = '0; last_tick = 1'b0;

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_step_idx", 64'(step_idx), 64'd0);
        chk("reset_audio", 64'(audio_out), 64'd0);
        chk("reset_tick", 64'(step_tick), 64'd0);
        chk("reset_view", 64'(view), 64'd0);
        repeat (3) cyc();

        // Edit/view vectors (NCH = 3, so edit_ch 3 is out of range).
        tbl[0] = '{ch: 2'd1, we: 1'b1, wd: 16'hA5A5, exp_view: 16'hA5A5};
        tbl[1] = '{ch: 2'd0, we: 1'b1, wd: 16'h1234, exp_view: 16'h1234};
        tbl[2] = '{ch: 2'd3, we: 1'b1, wd: 16'hFFFF, exp_view: 16'h0000};
        tbl[3] = '{ch: 2'd1, we: 1'b0, wd: 16'h0000, exp_view: 16'hA5A5};
        tbl[4] = '{ch: 2'd2, we: 1'b1, wd: 16'h0005, exp_view: 16'h0005};
        tbl[5] = '{ch: 2'd0, we: 1'b1, wd: 16'hFFFF, exp_view: 16'hFFFF};
        for (int i = 0; i < 6; i++) begin
            edit_ch = tbl[i].ch; we = tbl[i].we; wdata = tbl[i].wd;
            cyc();
            we = 1'b0;
            #1;
            chk($sformatf("tbl_view[%0d]", i), 64'(view), 64'(tbl[i].exp_view));
        end

        // Step timing with tones: ch1 has a full pattern but half 0.
        edit_ch = 2'd1; we = 1'b1; wdata = 16'hFFFF;
        cyc();
        we = 1'b0;
        set_half(0, 3); set_half(1, 0); set_half(2, 2);
        tempo = TW'(5); run = 1'b1; obs_ticks = 0; seen_audio = '0;
        repeat (80) cyc();
        chk("ticks_period5", 64'(obs_ticks), 64'd16);
        chk("step_wrap", 64'(step_idx), 64'd0);
        chk("ch1_muted", 64'(seen_audio[1]), 64'd0);
        chk("ch0_toggled", 64'(seen_audio[0]), 64'd1);
        tempo = '0; obs_ticks = 0;
        repeat (8) cyc();
        chk("ticks_period0", 64'(obs_ticks), 64'd4);
        chk("step_after_p0", 64'(step_idx), 64'd4);

        // Asynchronous reset mid-run, away from any clock edge.
        #2;
        rst = 1'b1; run = 1'b0;
        #1;
        chk("async_rst_audio", 64'(audio_out), 64'd0);
        chk("async_rst_step", 64'(step_idx), 64'd0);
        chk("async_rst_tick", 64'(step_tick), 64'd0);
        chk("async_rst_view", 64'(view), 64'd0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) cyc();
        chk("paused_step", 64'(step_idx), 64'd0);

        // Gating: ch2 plays only on steps 0 and 2.
        edit_ch = 2'd2; we = 1'b1; wdata = 16'h0005;
        cyc();
        we = 1'b0;
        tempo = TW'(100); run = 1'b1; hi_s0 = 1'b0; hi_off = 1'b0;
        for (int k = 0; k < 420; k++) begin
            #1;
            if (k < 100) hi_s0 |= audio_out[2];
            if ((k > 100 && k < 200) || (k > 300 && k < 400)) hi_off |= audio_out[2];
            cyc();
        end
        chk("gate_step0_active", 64'(hi_s0), 64'd1);
        chk("gate_steps13_low", 64'(hi_off), 64'd0);

        // Pattern write on the same cycle as a step advance.
        run = 1'b0;
        cyc();
        tempo = TW'(3); run = 1'b1;
        cyc();
        cyc();
        s0 = int'(step_idx);
        edit_ch = 2'd0; we = 1'b1; wdata = 16'h00F0;
        cyc();
        we = 1'b0;
        chk("coinc_tick", 64'(last_tick), 64'd1);
        chk("coinc_step", 64'(step_idx), 64'((s0 + 1) % ST));
        chk("coinc_view", 64'(view), 64'h00F0);
        repeat (10) cyc();

        // Randomised segments against the model.
        for (int s = 0; s < 6; s++) begin
            run = 1'b0; we = 1'b0;
            cyc();
            cyc();
            for (int c = 0; c < NCH; c++) begin
                set_half(c, ($urandom_range(0, 5) == 0) ? 0 : int'($urandom_range(1, 6)));
            end
            tempo = TW'($urandom_range(0, 6));
            for (int k = 0; k < 300; k++) begin
                run     = ($urandom_range(0, 29) != 0);
                we      = ($urandom_range(0, 7) == 0);
                edit_ch = CW'($urandom_range(0, 3));
                wdata   = ST'($urandom);
                if ($urandom_range(0, 19) == 0) tempo = TW'($urandom_range(0, 8));
`ifdef LOOP_LEN_EN
                if ($urandom_range(0, 49) == 0) loop_len = 5'($urandom_range(0, 20));
`endif
                cyc();
            end
        end
        we = 1'b0;

`ifdef LOOP_LEN_EN
        // Loop length: 4, shrink to 2 while on step 3, then 0 (acts as 1).
        run = 1'b0;
        cyc();
        tempo = TW'(2); loop_len = 5'd4; run = 1'b1;
        repeat (40) cyc();
        for (int k = 0; k < 20 && step_idx != SW'(3); k++) cyc();
        chk("loop_at_step3", 64'(step_idx), 64'd3);
        loop_len = 5'd2;
        repeat (2) cyc();
        chk("loop_shrink_to0", 64'(step_idx), 64'd0);
        repeat (10) cyc();
        loop_len = 5'd0; obs_ticks = 0;
        repeat (12) cyc();
        chk("loop_len0_step", 64'(step_idx), 64'd0);
        chk("loop_len0_ticks", 64'(obs_ticks), 64'd6);
        loop_len = 5'd16;
        repeat (4) cyc();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/multi_channel_sequencer.md
Name: multi_channel_sequencer

Overview:
Parametrised step sequencer that generalises the two-speaker composer to NUM_CH tone channels and STEPS steps. A shared tempo counter advances a step pointer. Each channel holds its own pattern register and drives a square wave on its audio output while its pattern bit at the current step is set. It sits between the switch/key front end (pattern editing, channel select) and the GPIO speaker pins, and it also supplies the LED view of the selected channel.

Parameters:
NUM_CH, 4, number of tone channels
STEPS, 16, steps per pattern
CH_W, 2, width of channel-select index (>= clog2(NUM_CH))
STEP_W, 4, width of step index (>= clog2(STEPS))
DIV_W, 20, width of per-channel tone half-period
TEMPO_W, 28, width of tempo period

Ports:
CLOCK_50  input  1  system clock, 50 MHz
reset  input  1  asynchronous, active-high reset
run  input  1  1 = sequencer advances and plays; 0 = paused and muted
tempo_period  input  TEMPO_W  CLOCK_50 cycles per step
tone_half_period  input  NUM_CH*DIV_W  per-channel half-period; channel c uses slice [c*DIV_W +: DIV_W]
edit_ch  input  CH_W  channel selected for edit and view
pattern_we  input  1  write strobe for the pattern
pattern_wdata  input  STEPS  new pattern for edit_ch
audio_out  output  NUM_CH  square-wave output per channel (GPIO)
pattern_view  output  STEPS  pattern of edit_ch (LEDR)
step_idx  output  STEP_W  current step
step_tick  output  1  one-cycle pulse on each step advance

Behaviour:
- Reset (asynchronous, active-high): all pattern registers = 0, tempo counter = 0, step_idx = 0, every tone counter = 0, audio_out = 0, step_tick = 0.
- Tempo:
  - Effective period P = max(tempo_period, 2).
  - While run = 1, the tempo counter counts 0..P-1.
  - At count P-1: the counter wraps to 0, step_tick = 1 for exactly that cycle, and step_idx increments on the same edge.
  - step_idx wraps from STEPS-1 to 0.
- Pause:
  - run = 0: tempo counter is held at 0, step_idx is held, step_tick = 0, all audio_out = 0, tone counters are cleared.
  - run 0->1: the first step_tick comes P cycles later; step_idx resumes from its held value.
- Changing tempo_period mid-step: the new P applies immediately. If the counter is already >= new P-1, it wraps on the next cycle.
- Gate: gate[c] = run & pattern[c][step_idx] & (half[c] != 0). A channel with half = 0 is muted.
- Tone generator, per channel:
  - While gate[c] = 1, the counter counts 0..half[c]-1; at half[c]-1 it wraps and audio_out[c] toggles.
  - While gate[c] = 0, the counter is 0 and audio_out[c] = 0.
  - On a gate rise the output starts low; the first toggle comes half[c] cycles later.
  - audio_out is registered.
- Pattern write:
  - A pattern_we edge loads pattern[edit_ch] = pattern_wdata; the value is visible on the next cycle.
  - If edit_ch >= NUM_CH, the write is ignored.
  - A write coinciding with a step advance: both take effect, and the gate uses the new pattern and new step from the next cycle.
- pattern_view = pattern[edit_ch], combinational from registers; 0 when edit_ch >= NUM_CH.
- Latency: a step advance reaches audio_out gating on the cycle after step_tick.

Optional Feature:
LOOP_LEN_EN
- Defined: adds input loop_len [STEP_W:0]. step_idx wraps to 0 after step L-1, where L = clamp(loop_len, 1, STEPS).
  - If loop_len is reduced so that L <= step_idx, the next advance goes to 0.
  - L = 1 holds step 0 but step_tick still pulses.
- Undefined: no port; the loop length is always STEPS.

Test Plan:
1. Reset check: assert reset mid-run with tones active -> all outputs 0 asynchronously; after release with run = 0, step_idx stays 0 and audio_out stays 0.
2. Step timing: run = 1, tempo_period = 5 -> step_tick pulses every 5 cycles, step_idx goes 0,1,…,15,0; tempo_period = 0 -> a tick every 2 cycles.
3. Tone generation: pattern ch0 = 16'hFFFF, half0 = 3 -> audio_out[0] toggles every 3 cycles, starting low. half1 = 0 with pattern all ones -> audio_out[1] stays 0.
4. Gating: ch2 pattern = 16'h0005, tempo_period = 100 -> audio_out[2] is active during steps 0 and 2 only, and low from the cycle after the tick into steps 1 and 3.
5. Edit and view:
   - Write edit_ch = 1, wdata = 16'hA5A5 -> pattern_view = A5A5 the next cycle.
   - edit_ch = 3 with NUM_CH = 3 -> the write is ignored and pattern_view = 0.
   - Write on the same cycle as step_tick -> both the write and the advance take effect.
6. LOOP_LEN_EN: loop_len = 4 -> steps cycle 0..3. Change loop_len to 2 while step_idx = 3 -> next step is 0. loop_len = 0 -> treated as 1.
